// File: rtl/joypad_reader.sv
// joypad_reader: host-side reader for an NES/SNES-style serial gamepad.
// Every POLL_CYCLES clocks, or on poll_req, it pulses pad_latch, clocks BITS
// buttons out of the pad on pad_clk, samples the active-low pad_data line and
// presents the word active-high on buttons with a one-cycle valid strobe.
// Optional feature: define JOYPAD_DEBOUNCE_EN to accept a word only when two
// consecutive frames agree (a raw-word register holds the previous frame).

module joypad_reader #(
    parameter int FREQ        = 37_800_000,
    parameter int POLLRATE    = 60,
    parameter int HALF_CYCLES = FREQ / 166_667,
    parameter int BITS        = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            poll_req,
    input  logic            pad_data,
    output logic            pad_latch,
    output logic            pad_clk,
    output logic [BITS-1:0] buttons,
    output logic            valid,
    output logic            busy
);

    localparam int POLL_CYCLES = FREQ / POLLRATE;
    localparam int TW          = $clog2(POLL_CYCLES);
    localparam int BW          = $clog2(BITS + 1);
    localparam int PW          = $clog2(2 * HALF_CYCLES);

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   phase, phase_next;
    logic [BW-1:0]   bit_cnt, bit_next;
    logic [TW-1:0]   timer;
    logic            sync_q1, sync_q2;
    logic [BITS-1:0] shift_q;
    logic            start_req;
    logic            sample_now;
    logic            frame_end;
    logic            latch_next, pad_clk_next, valid_next, busy_next;

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value, regardless of statement order.
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= pad_data;
            sync_q2 <= sync_q1;
        end
    end

    // Free-running poll timer; a frame is requested as it wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign start_req  = (timer == TIMER_LAST) || poll_req;
    assign sample_now = (state == LOW) && (phase == '0);
    assign frame_end  = (state == HIGH) && (phase == HALF_LAST) && (bit_cnt == BIT_LAST);

    // Next-state, phase/bit counters and next output values.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        phase_next = phase + 1'b1;
        bit_next   = bit_cnt;

        case (state)
            IDLE: begin
                phase_next = '0;
                // Requests seen in any other state are dropped, not queued.
                if (start_req) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_next = LOW;
                    phase_next = '0;
                    bit_next   = '0;
                end
            end
            LOW: begin
                if (phase == HALF_LAST) begin
                    state_next = HIGH;
                    phase_next = '0;
                end
            end
            HIGH: begin
                if (phase == HALF_LAST) begin
                    phase_next = '0;
                    bit_next   = bit_cnt + 1'b1;
                    state_next = (bit_cnt == BIT_LAST) ? DONE : LOW;
                end
            end
            DONE: begin
                state_next = IDLE;
                phase_next = '0;
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase

        // Outputs are registered from the next state so the pad pins never glitch.
        latch_next   = (state_next == LATCH);
        pad_clk_next = (state_next != LOW);
        valid_next   = (state_next == DONE);
        busy_next    = (state_next != IDLE);
    end

    // State register and registered pad/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            bit_cnt   <= bit_next;
            pad_latch <= latch_next;
            pad_clk   <= pad_clk_next;
            valid     <= valid_next;
            busy      <= busy_next;
        end
    end

    // Capture bit k (inverted to active-high) on the first cycle of its LOW phase.
    always_ff @(posedge clk) begin
        // NOTE: every shift bit is rewritten before use each frame; the reset
        // only keeps the register free of X before the first frame.
        if (reset) begin
            shift_q <= '0;
        end else if (sample_now) begin
            for (int i = 0; i < BITS; i++) begin
                if (bit_cnt == BW'(i)) begin
                    shift_q[i] <= ~sync_q2;
                end
            end
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    logic [BITS-1:0] raw_q;

    // Load buttons at the end of the last HIGH phase (visible in DONE) only
    // when this frame matches the previous raw frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q   <= '0;
            buttons <= '0;
        end else if (frame_end) begin
            raw_q <= shift_q;
            if (shift_q == raw_q) begin
                buttons <= shift_q;
            end
        end
    end
`else
    // Load buttons at the end of the last HIGH phase so they are visible in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons <= '0;
        end else if (frame_end) begin
            buttons <= shift_q;
        end
    end
`endif

endmodule

// File: tb/tb_joypad_reader.sv
// tb_joypad_reader: scoreboard bench for joypad_reader.
// A behavioural pad model answers the latch/clock protocol; stimulus pushes
// expected button words into a queue and a monitor pops them on each valid.

module tb_joypad_reader;

    localparam int FREQ     = 1000;
    localparam int POLLRATE = 10;
    localparam int H        = 4;
    localparam int BITS     = 8;
    localparam int FRAME    = 2 * H + 2 * H * BITS;   // 72

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            poll_req = 1'b0;
    logic            pad_data = 1'b1;
    logic            pad_latch;
    logic            pad_clk;
    logic [BITS-1:0] buttons;
    logic            valid;
    logic            busy;

    joypad_reader #(
        .FREQ        (FREQ),
        .POLLRATE    (POLLRATE),
        .HALF_CYCLES (H),
        .BITS        (BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .poll_req  (poll_req),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- pad model ----------------
    logic [BITS-1:0] pad_word = '0;
    logic [BITS-1:0] pad_sr = '0;
    logic            glitch_en = 1'b0;
    int              pad_cyc = 0;
    logic            pm_prev_clk = 1'b1;
    logic            pm_prev_latch = 1'b0;

    // pad_data value set at the negedge of cycle c is the value during cycle c.
    always @(negedge clk) begin
        if (pad_latch && !pm_prev_latch) pad_cyc = 0;
        else pad_cyc++;
        if (pad_latch) pad_sr = pad_word;
        else if (pad_clk && !pm_prev_clk) pad_sr = pad_sr >> 1;
        pm_prev_clk   = pad_clk;
        pm_prev_latch = pad_latch;
        // Glitch window: last latch cycle through the LOW phase of bit 0.
        if (glitch_en && pad_cyc >= 2 * H - 1 && pad_cyc <= 3 * H - 1)
            pad_data = pad_sr[0];
        else
            pad_data = ~pad_sr[0];
    end

    // ---------------- scoreboard / monitor ----------------
    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] exp_word;
    int   valid_count = 0;
    int   rise_count = 0;
    int   last_rise = 0;
    int   latch_len = 0;
    int   low_cycles = 0;
    int   low_pulses = 0;
    logic mon_prev_latch = 1'b0;
    logic mon_prev_clk = 1'b1;

    always @(negedge clk) begin
        if (pad_latch && !mon_prev_latch) begin
            rise_count++;
            last_rise  = cyc;
            latch_len  = 0;
            low_cycles = 0;
            low_pulses = 0;
        end
        if (pad_latch) latch_len++;
        if (!pad_clk) begin
            low_cycles++;
            if (mon_prev_clk) low_pulses++;
        end
        if (valid) begin
            valid_count++;
            check("valid_latency", 32'(cyc - last_rise), 32'(FRAME));
            check("latch_width", 32'(latch_len), 32'(2 * H));
            check("clk_low_pulses", 32'(low_pulses), 32'(BITS));
            check("clk_low_cycles", 32'(low_cycles), 32'(BITS * H));
            check("busy_at_valid", 32'(busy), 32'(1));
            check("valid_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                check("buttons", 32'(buttons), 32'(exp_word));
            end
        end
        mon_prev_latch = pad_latch;
        mon_prev_clk   = pad_clk;
    end

    // ---------------- expected-value model ----------------
    logic [BITS-1:0] mdl_buttons = '0;
    logic [BITS-1:0] mdl_raw = '0;

    task automatic expect_frame(input logic [BITS-1:0] w);
        pad_word = w;
`ifdef JOYPAD_DEBOUNCE_EN
        if (w == mdl_raw) mdl_buttons = w;
        mdl_raw = w;
`else
        mdl_buttons = w;
`endif
        exp_q.push_back(mdl_buttons);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int start = valid_count;
        int n = 0;
        while (valid_count == start && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(valid_count - start), 32'(1));
    endtask

    task automatic wait_rise(input string name, input int budget);
        int start = rise_count;
        int n = 0;
        while (rise_count == start && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(rise_count - start), 32'(1));
    endtask

    task automatic poll_frame(input logic [BITS-1:0] w, input logic g);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("idle_before_poll", 32'(busy), 32'(0));
        glitch_en = g;
        expect_frame(w);
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_valid("poll_frame_valid", FRAME + 10);
        glitch_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int rel, first_rise, req, vc0, rc0, vc1;

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        rel = cyc;
        check("rst_pad_latch", 32'(pad_latch), 32'(0));
        check("rst_pad_clk", 32'(pad_clk), 32'(1));
        check("rst_buttons", 32'(buttons), 32'(0));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));

        // Timer-driven frames: all released, then A+Start.
        expect_frame(8'h00);
        wait_rise("first_rise", 120);
        check("first_frame_start", 32'(last_rise - rel), 32'(100));
        check("busy_at_rise", 32'(busy), 32'(1));
        first_rise = last_rise;
        wait_valid("first_valid", FRAME + 10);

        expect_frame(8'h09);
        wait_rise("second_rise", 120);
        check("frame_period", 32'(last_rise - first_rise), 32'(100));
        wait_valid("second_valid", FRAME + 10);

        // poll_req in IDLE, then poll_req and a timer wrap while busy.
        repeat (3) step();
        check("idle_after_frame", 32'(busy), 32'(0));
        vc0 = valid_count;
        rc0 = rise_count;
        expect_frame(8'h5A);
        poll_req = 1'b1;
        req = cyc;
        step();
        poll_req = 1'b0;
        check("poll_latch_next_cycle", 32'(pad_latch), 32'(1));
        check("poll_start_cycle", 32'(last_rise - req), 32'(1));
        repeat (20) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_valid("poll_valid", FRAME + 10);
        wait_rise("timer_after_poll", 120);
        check("frames_during_busy", 32'(rise_count - rc0), 32'(2));
        check("valids_during_busy", 32'(valid_count - vc0), 32'(1));

        // Reset at cycle 30 of this timer frame aborts it.
        repeat (30) step();
        check("busy_mid_frame", 32'(busy), 32'(1));
        reset = 1'b1;
        vc1 = valid_count;
        step();
        check("abort_pad_latch", 32'(pad_latch), 32'(0));
        check("abort_pad_clk", 32'(pad_clk), 32'(1));
        check("abort_buttons", 32'(buttons), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_valid", 32'(valid), 32'(0));
        step();
        reset = 1'b0;
        mdl_buttons = '0;
        mdl_raw = '0;
        repeat (5) step();
        check("no_valid_after_abort", 32'(valid_count - vc1), 32'(0));

        // Debounce sequence (expected values follow the build configuration).
        poll_frame(8'h01, 1'b0);
        poll_frame(8'h03, 1'b0);
        poll_frame(8'h03, 1'b0);

        // pad_data toggled across the last latch cycle and bit 0's LOW phase.
        poll_frame(8'h06, 1'b1);
        poll_frame(8'h06, 1'b1);

        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
